// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator scheduler: FSM state, travel
// direction encodings and call-mask search functions.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Masks are passed zero-extended to the largest supported shaft.
    localparam int unsigned MAX_FLOORS = 64;

    function automatic logic calls_above(input logic [MAX_FLOORS-1:0] mask, input int unsigned f);
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (i > f && mask[i]) found = 1'b1;
        end
        return found;
    endfunction

    function automatic logic calls_below(input logic [MAX_FLOORS-1:0] mask, input int unsigned f);
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (i < f && mask[i]) found = 1'b1;
        end
        return found;
    endfunction

endpackage

// File: rtl/floor_stop_check.sv
// Combinational stop decision for one floor and travel direction, plus the
// one-hot masks of the pending calls that a stop there serves.
module floor_stop_check
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [FLOOR_W-1:0]    i_floor,
    input  logic                  i_dir,
    input  logic [NUM_FLOORS-1:0] i_pend_in,
    input  logic [NUM_FLOORS-1:0] i_pend_up,
    input  logic [NUM_FLOORS-1:0] i_pend_down,
    output logic                  o_stop,
    output logic [NUM_FLOORS-1:0] o_clr_in,
    output logic [NUM_FLOORS-1:0] o_clr_up,
    output logic [NUM_FLOORS-1:0] o_clr_down
);

    logic [MAX_FLOORS-1:0] w_all;
    logic [NUM_FLOORS-1:0] w_onehot;
    logic                  w_beyond;
    logic                  w_match;
    logic                  w_opp_stop;

    always_comb begin
        w_all    = MAX_FLOORS'(i_pend_in | i_pend_up | i_pend_down);
        w_onehot = '0;
        w_onehot[i_floor] = 1'b1;

        w_beyond = (i_dir == DIR_DOWN) ? calls_below(w_all, 32'(i_floor))
                                       : calls_above(w_all, 32'(i_floor));
        w_match  = (i_dir == DIR_UP) ? i_pend_up[i_floor] : i_pend_down[i_floor];
        // An opposite hall call only turns the car round when nothing lies further on.
        w_opp_stop = ((i_dir == DIR_UP) ? i_pend_down[i_floor] : i_pend_up[i_floor]) & ~w_beyond;

        o_stop     = i_pend_in[i_floor] | w_match | w_opp_stop;
        o_clr_in   = w_onehot;
        o_clr_up   = ((i_dir == DIR_UP) || w_opp_stop) ? w_onehot : '0;
        o_clr_down = ((i_dir == DIR_DOWN) || w_opp_stop) ? w_onehot : '0;
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car controller: call latching, floor stepping, door timing and
// direction scheduling. Define ELEV_DOOR_HOLD_EN to add the i_door_hold input.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = 8,
    parameter int unsigned FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [NUM_FLOORS-1:0] i_call_in,
    input  logic [NUM_FLOORS-1:0] i_call_up,
    input  logic [NUM_FLOORS-1:0] i_call_down,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  i_door_hold,
`endif
    output logic [FLOOR_W-1:0]    o_cur_floor,
    output logic                  o_direction,
    output logic                  o_moving,
    output logic                  o_door_open,
    output logic [NUM_FLOORS-1:0] o_pending_in,
    output logic [NUM_FLOORS-1:0] o_pending_up,
    output logic [NUM_FLOORS-1:0] o_pending_down
);

    localparam int unsigned TMR_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] MOVE_LAST = TMR_W'(MOVE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LAST = TMR_W'(DOOR_CYCLES - 1);
    // No up call from the top floor, no down call from the bottom floor.
    localparam logic [NUM_FLOORS-1:0] UP_MASK   = {NUM_FLOORS{1'b1}} >> 1;
    localparam logic [NUM_FLOORS-1:0] DOWN_MASK = {NUM_FLOORS{1'b1}} << 1;

    state_e                r_state;
    logic [FLOOR_W-1:0]    r_cur_floor;
    logic                  r_dir;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_moving;
    logic                  r_door_open;
    logic [NUM_FLOORS-1:0] r_pend_in;
    logic [NUM_FLOORS-1:0] r_pend_up;
    logic [NUM_FLOORS-1:0] r_pend_down;

    logic [MAX_FLOORS-1:0] w_pend_all;
    logic [FLOOR_W-1:0]    w_next_floor;
    logic [FLOOR_W-1:0]    w_chk_floor;
    logic                  w_stop;
    logic                  w_ahead;
    logic                  w_behind;
    logic                  w_clr_en;
    logic                  w_hold;
    logic [NUM_FLOORS-1:0] w_clr_in;
    logic [NUM_FLOORS-1:0] w_clr_up;
    logic [NUM_FLOORS-1:0] w_clr_down;

`ifdef ELEV_DOOR_HOLD_EN
    assign w_hold = i_door_hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_pend_all   = MAX_FLOORS'(r_pend_in | r_pend_up | r_pend_down);
    assign w_next_floor = (r_dir == DIR_UP) ? r_cur_floor + FLOOR_W'(1)
                                            : r_cur_floor - FLOOR_W'(1);
    // While moving, the stop test looks at the floor about to be reached.
    assign w_chk_floor  = (r_state == ST_MOVE) ? w_next_floor : r_cur_floor;
    assign w_ahead  = (r_dir == DIR_UP) ? calls_above(w_pend_all, 32'(r_cur_floor))
                                        : calls_below(w_pend_all, 32'(r_cur_floor));
    assign w_behind = (r_dir == DIR_UP) ? calls_below(w_pend_all, 32'(r_cur_floor))
                                        : calls_above(w_pend_all, 32'(r_cur_floor));
    assign w_clr_en = (r_state == ST_DOOR)
                   || (r_state == ST_IDLE && w_stop)
                   || (r_state == ST_MOVE && r_timer == MOVE_LAST && w_stop);

    floor_stop_check #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_stop (
        .i_floor     (w_chk_floor),
        .i_dir       (r_dir),
        .i_pend_in   (r_pend_in),
        .i_pend_up   (r_pend_up),
        .i_pend_down (r_pend_down),
        .o_stop      (w_stop),
        .o_clr_in    (w_clr_in),
        .o_clr_up    (w_clr_up),
        .o_clr_down  (w_clr_down)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend_in   <= '0;
            r_pend_up   <= '0;
            r_pend_down <= '0;
        end else begin
            r_pend_in   <= (r_pend_in | i_call_in) & ~(w_clr_en ? w_clr_in : '0);
            r_pend_up   <= (r_pend_up | (i_call_up & UP_MASK)) & ~(w_clr_en ? w_clr_up : '0);
            r_pend_down <= (r_pend_down | (i_call_down & DOWN_MASK))
                         & ~(w_clr_en ? w_clr_down : '0);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cur_floor <= '0;
            r_dir       <= DIR_UP;
            r_timer     <= '0;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (w_stop) begin
                        r_state     <= ST_DOOR;
                        r_door_open <= 1'b1;
                    end else if (w_ahead || w_behind) begin
                        r_state  <= ST_MOVE;
                        r_moving <= 1'b1;
                        if (!w_ahead) r_dir <= ~r_dir;
                    end
                end
                ST_MOVE: begin
                    if (r_timer == MOVE_LAST) begin
                        r_cur_floor <= w_next_floor;
                        r_timer     <= '0;
                        if (w_stop) begin
                            r_state     <= ST_DOOR;
                            r_moving    <= 1'b0;
                            r_door_open <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_DOOR: begin
                    if (w_hold) begin
                        r_timer <= '0;
                    end else if (r_timer == DOOR_LAST) begin
                        r_timer     <= '0;
                        r_door_open <= 1'b0;
                        if (w_ahead || w_behind) begin
                            r_state  <= ST_MOVE;
                            r_moving <= 1'b1;
                            if (!w_ahead) r_dir <= ~r_dir;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_moving    <= 1'b0;
                    r_door_open <= 1'b0;
                end
            endcase
        end
    end

    assign o_cur_floor    = r_cur_floor;
    assign o_direction    = r_dir;
    assign o_moving       = r_moving;
    assign o_door_open    = r_door_open;
    assign o_pending_in   = r_pend_in;
    assign o_pending_up   = r_pend_up;
    assign o_pending_down = r_pend_down;

endmodule
